// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_buffer
// Description : PC/ALU execution-trace capture beside the CPU core. Records
//               each new (pc, alu) pair into a circular buffer, triggers on a
//               PC match or a detected halt, captures POST_TRIG further
//               samples, freezes, then reads out oldest-first via pops.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 8,
  parameter int HALT_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic [DATA_W-1:0]        alu_in,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic                     halt_trig,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_alu,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     halted
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_HC_W  = $clog2(HALT_CYCLES);

  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [c_HC_W-1:0]  c_HC_MAX    = c_HC_W'(HALT_CYCLES - 1);
  // Post-trigger counter value on which the final window sample lands.
  localparam logic [c_PTR_W-1:0] c_POST_LAST = c_PTR_W'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ADDR_W-1:0]    r_mem_pc  [DEPTH];
  logic [DATA_W-1:0]    r_mem_alu [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_PTR_W-1:0]   r_post_cnt;
  logic [c_PTR_W-1:0]   w_post_cnt_next;

  logic [ADDR_W-1:0]    r_last_pc;
  logic                 r_first;
  logic [c_HC_W-1:0]    r_halt_cnt;
  logic [c_HC_W-1:0]    w_halt_cnt_next;
  logic                 r_halted;
  logic                 w_halted_next;

  logic                 r_rd_valid;
  logic [ADDR_W-1:0]    r_rd_pc;
  logic [DATA_W-1:0]    r_rd_alu;

  logic                 w_pc_same;
  logic                 w_capturing;
  logic                 w_capture;
  logic                 w_trig_hit;
  logic                 w_halt_event;
  logic                 w_pop;

  // Per-cycle event decode; arm overrides every capture, trigger and pop.
  always_comb begin
    w_pc_same       = (pc_in == r_last_pc);
    w_halt_cnt_next = r_halt_cnt;
    if (!w_pc_same) begin
      w_halt_cnt_next = '0;
    end else if (r_halt_cnt != c_HC_MAX) begin
      w_halt_cnt_next = r_halt_cnt + 1'b1;
    end
    w_halted_next = (w_halt_cnt_next == c_HC_MAX);
    w_capturing   = (r_state == ST_ARMED) || (r_state == ST_POST);
    w_capture     = w_capturing && (r_first || !w_pc_same) && !arm;
    w_trig_hit    = (r_state == ST_ARMED) && w_capture && trig_en && (pc_in == trig_pc);
    w_halt_event  = (r_state == ST_ARMED) && halt_trig && w_halted_next && !r_halted && !arm;
    w_pop         = (r_state == ST_DONE) && (r_count != '0) && rd_en && !arm;
  end

  // Next-state logic and post-trigger sample counting.
  always_comb begin
    w_state_next    = r_state;
    w_post_cnt_next = r_post_cnt;
    if (arm) begin
      w_state_next    = ST_ARMED;
      w_post_cnt_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_IDLE;
        end
        ST_ARMED: begin
          // A PC match wins over a simultaneous halt edge so the sample is kept.
          if (w_trig_hit || w_halt_event) begin
            w_state_next    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
            w_post_cnt_next = '0;
          end
        end
        ST_POST: begin
          if (w_capture) begin
            if (r_post_cnt == c_POST_LAST) begin
              w_state_next = ST_DONE;
            end else begin
              w_post_cnt_next = r_post_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register and post-trigger counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_post_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_post_cnt <= w_post_cnt_next;
    end
  end

  // PC history, first-sample flag and halt detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_pc  <= '0;
      r_first    <= 1'b0;
      r_halt_cnt <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_last_pc <= pc_in;
      if (arm) begin
        r_first    <= 1'b1;
        r_halt_cnt <= '0;
        r_halted   <= 1'b0;
      end else begin
        r_first    <= 1'b0;
        r_halt_cnt <= w_halt_cnt_next;
        r_halted   <= w_halted_next;
      end
    end
  end

  // Sample storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_pc[r_wr_ptr]  <= pc_in;
      r_mem_alu[r_wr_ptr] <= alu_in;
    end
  end

  // Circular-buffer pointers and occupancy; a full buffer drops its oldest entry.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_capture) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_count == c_FULL) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  // Readout port: one-cycle pop latency, data held between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_alu   <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_pc  <= r_mem_pc[r_rd_ptr];
        r_rd_alu <= r_mem_alu[r_rd_ptr];
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_pc    = r_rd_pc;
  assign rd_alu   = r_rd_alu;
  assign count    = r_count;
  assign state    = r_state;
  assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_trace_buffer
// Description : Directed self-checking bench for cpu_trace_buffer: reset,
//               PC trigger, wrap, halt trigger (vector table), arm during
//               readout and ignored pops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pc_in = '0;
  logic [23:0] alu_in = '0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [23:0] trig_pc = '0;
  logic        halt_trig = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [23:0] rd_pc;
  logic [23:0] rd_alu;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        halted;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        arm;
    logic        rd_en;
    logic [23:0] pc;
    logic [1:0]  exp_state;
    logic [4:0]  exp_count;
    logic        exp_halted;
    logic        exp_rd_valid;
    logic        chk_data;
    logic [23:0] exp_rd_pc;
  } vec_t;

  vec_t tbl [29];

  cpu_trace_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .alu_in    (alu_in),
    .arm       (arm),
    .trig_en   (trig_en),
    .trig_pc   (trig_pc),
    .halt_trig (halt_trig),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_alu    (rd_alu),
    .count     (count),
    .state     (state),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] alu_of(input logic [23:0] pc);
    return pc ^ 24'h5A5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pc(input logic [23:0] pc);
    pc_in  = pc;
    alu_in = alu_of(pc);
  endtask

  task automatic do_arm(input logic [23:0] pc);
    arm = 1'b1;
    drive_pc(pc);
    step();
    arm = 1'b0;
  endtask

  task automatic pops(input int first_pc, input int n, input int start_cnt);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      step();
      check("pop_valid", {31'd0, rd_valid}, 32'd1);
      check("pop_pc", {8'd0, rd_pc}, first_pc + i);
      check("pop_alu", {8'd0, rd_alu}, {8'd0, alu_of(24'(first_pc + i))});
      check("pop_count", {27'd0, count}, start_cnt - 1 - i);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    // Halt-trigger vector table: arm, hold pc=5, then 8 new PCs, then readout.
    for (int i = 0; i < 29; i++) begin
      tbl[i] = '{arm: 1'b0, rd_en: 1'b0, pc: 24'd0, exp_state: 2'd1, exp_count: 5'd0,
                 exp_halted: 1'b0, exp_rd_valid: 1'b0, chk_data: 1'b0, exp_rd_pc: 24'd0};
    end
    tbl[0].arm = 1'b1;
    tbl[0].pc  = 24'd100;
    for (int i = 1; i <= 10; i++) begin
      tbl[i].pc         = 24'd5;
      tbl[i].exp_count  = 5'd1;
      tbl[i].exp_state  = (i >= 8) ? 2'd2 : 2'd1;
      tbl[i].exp_halted = (i >= 8);
    end
    for (int i = 11; i <= 18; i++) begin
      tbl[i].pc        = 24'(i - 5);
      tbl[i].exp_count = 5'(i - 9);
      tbl[i].exp_state = (i == 18) ? 2'd3 : 2'd2;
    end
    for (int i = 19; i <= 27; i++) begin
      tbl[i].rd_en        = 1'b1;
      tbl[i].pc           = 24'(200 + i);
      tbl[i].exp_state    = 2'd3;
      tbl[i].exp_count    = 5'(8 - (i - 19));
      tbl[i].exp_rd_valid = 1'b1;
      tbl[i].chk_data     = 1'b1;
      tbl[i].exp_rd_pc    = 24'(5 + (i - 19));
    end
    tbl[28].rd_en     = 1'b1;
    tbl[28].pc        = 24'd300;
    tbl[28].exp_state = 2'd3;
    tbl[28].chk_data  = 1'b1;
    tbl[28].exp_rd_pc = 24'd13;

    // T1: reset with toggling pc_in
    rst = 1'b1;
    drive_pc(24'h123456);
    step();
    drive_pc(24'h654321);
    step();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_rd_pc", {8'd0, rd_pc}, 32'd0);
    check("rst_rd_alu", {8'd0, rd_alu}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_state", {30'd0, state}, 32'd0);

    // T2: PC trigger at 20, window of 8 more samples
    trig_en = 1'b1;
    trig_pc = 24'd20;
    do_arm(24'hFFFF00);
    check("t2_armed", {30'd0, state}, 32'd1);
    check("t2_arm_count", {27'd0, count}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      drive_pc(24'(i));
      step();
      if (i == 19) check("t2_pre_trig", {30'd0, state}, 32'd1);
      if (i == 20) check("t2_post", {30'd0, state}, 32'd2);
      if (i == 27) check("t2_still_post", {30'd0, state}, 32'd2);
      if (i == 28) check("t2_done", {30'd0, state}, 32'd3);
    end
    check("t2_final_state", {30'd0, state}, 32'd3);
    check("t2_final_count", {27'd0, count}, 32'd16);
    pops(13, 16, 16);
    step();
    check("t2_valid_pulse", {31'd0, rd_valid}, 32'd0);
    // T6a: pop in DONE with empty buffer
    rd_en = 1'b1;
    step();
    check("t6_empty_valid", {31'd0, rd_valid}, 32'd0);
    check("t6_empty_count", {27'd0, count}, 32'd0);
    check("t6_empty_hold", {8'd0, rd_pc}, 32'd28);
    rd_en = 1'b0;

    // T3: wrap without trigger, then trigger at 40
    trig_pc = 24'hFFFFFF;
    do_arm(24'hABCDEF);
    for (int i = 0; i < 40; i++) begin
      drive_pc(24'(i));
      step();
      if (i == 3) check("t3_fill_count", {27'd0, count}, 32'd4);
    end
    check("t3_armed", {30'd0, state}, 32'd1);
    check("t3_sat_count", {27'd0, count}, 32'd16);
    trig_pc = 24'd40;
    for (int i = 40; i <= 48; i++) begin
      drive_pc(24'(i));
      step();
    end
    check("t3_done", {30'd0, state}, 32'd3);
    check("t3_count", {27'd0, count}, 32'd16);
    pops(33, 16, 16);

    // T5: arm together with rd_en mid-readout
    trig_pc = 24'd20;
    do_arm(24'hFFFF00);
    for (int i = 0; i <= 28; i++) begin
      drive_pc(24'(i));
      step();
    end
    check("t5_done", {30'd0, state}, 32'd3);
    pops(13, 3, 16);
    arm   = 1'b1;
    rd_en = 1'b1;
    step();
    arm = 1'b0;
    check("t5_count", {27'd0, count}, 32'd0);
    check("t5_state", {30'd0, state}, 32'd1);
    check("t5_no_valid", {31'd0, rd_valid}, 32'd0);
    // T6b: rd_en while ARMED; only the forced first sample is taken
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_armed_valid", {31'd0, rd_valid}, 32'd0);
      check("t6_armed_count", {27'd0, count}, 32'd1);
    end
    rd_en = 1'b0;

    // T4: halt trigger, table-driven
    trig_en   = 1'b0;
    halt_trig = 1'b1;
    for (int i = 0; i < 29; i++) begin
      arm   = tbl[i].arm;
      rd_en = tbl[i].rd_en;
      drive_pc(tbl[i].pc);
      step();
      check($sformatf("t4_state[%0d]", i), {30'd0, state}, {30'd0, tbl[i].exp_state});
      check($sformatf("t4_count[%0d]", i), {27'd0, count}, {27'd0, tbl[i].exp_count});
      check($sformatf("t4_halted[%0d]", i), {31'd0, halted}, {31'd0, tbl[i].exp_halted});
      check($sformatf("t4_valid[%0d]", i), {31'd0, rd_valid}, {31'd0, tbl[i].exp_rd_valid});
      if (tbl[i].chk_data) begin
        check($sformatf("t4_rd_pc[%0d]", i), {8'd0, rd_pc}, {8'd0, tbl[i].exp_rd_pc});
        check($sformatf("t4_rd_alu[%0d]", i), {8'd0, rd_alu}, {8'd0, alu_of(tbl[i].exp_rd_pc)});
      end
    end
    arm   = 1'b0;
    rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
